// File: rtl/grant_issuer_pkg.sv
// Shared arbitration types: grant FSM state encoding and the index-to-one-hot helper.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } grant_state_t;

    localparam int ONEHOT_MAX_W = 64;

    // Generic index-to-one-hot conversion; callers truncate to their own width.
    function automatic logic [ONEHOT_MAX_W-1:0] onehot_of(input int unsigned idx);
        logic [ONEHOT_MAX_W-1:0] v;
        v = '0;
        if (idx < ONEHOT_MAX_W) v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/grant_issuer_onehot_decoder.sv
// Combinational index-to-one-hot decoder; output is all-zero when disabled
// or when the index does not address a real requester.
module onehot_decoder
    import arb_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic [IDX_W-1:0] i_idx,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_onehot
);

    always_comb begin
        o_onehot = '0;
        for (int i = 0; i < WIDTH; i++) begin
            o_onehot[i] = i_en && (32'(i_idx) == i);
        end
    end

endmodule

// File: rtl/grant_issuer.sv
// Decodes an accepted arbiter index into a held one-hot grant and reports its release.
// Optional forced release after MAX_HOLD grant cycles when GRANT_TIMEOUT_EN is defined.
module grant_issuer
    import arb_pkg::*;
#(
    parameter  int WIDTH    = 4,
    parameter  int MAX_HOLD = 16,
    localparam int IDX_W    = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [IDX_W-1:0] i_idx,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_gnt,
    input  logic [WIDTH-1:0] i_done,
    output logic             o_release,
    output logic [IDX_W-1:0] o_release_idx,
    output logic             o_err,
    output logic             o_timeout,
    output grant_state_t     o_state
);

    if (WIDTH < 2) begin : g_bad_width
        $error("grant_issuer: WIDTH must be at least 2");
    end
    if (MAX_HOLD < 1) begin : g_bad_hold
        $error("grant_issuer: MAX_HOLD must be at least 1");
    end

    // Handshake: an index transfers on a rising edge where i_valid && o_ready.
    // o_ready depends on state only, so the source may hold i_valid across a
    // busy grant and the index is consumed on the first edge back in IDLE.

    grant_state_t     state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [WIDTH-1:0] gnt_q, gnt_d;
    logic             release_q, release_d;
    logic [IDX_W-1:0] release_idx_q, release_idx_d;
    logic             err_q, err_d;
    logic             timeout_q, timeout_d;

    logic             in_range;
    logic             accept;
    logic             reject;
    logic             done_hit;
    logic             force_rel;
    logic [WIDTH-1:0] dec_onehot;

    assign in_range = ({1'b0, i_idx} < (IDX_W+1)'(WIDTH));
    assign accept   = (state_q == IDLE) && i_valid && in_range;
    assign reject   = (state_q == IDLE) && i_valid && !in_range;
    // gnt_q is the owner's one-hot, so masking i_done with it honours only the owner.
    assign done_hit = (state_q == GRANT) && |(i_done & gnt_q);

    onehot_decoder #(.WIDTH(WIDTH)) u_dec (
        .i_idx    (i_idx),
        .i_en     (accept),
        .o_onehot (dec_onehot)
    );

`ifdef GRANT_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD + 1);
    logic [CNT_W-1:0] hold_cnt_q;

    // hold_cnt_q counts completed grant cycles, so MAX_HOLD-1 marks the last one.
    assign force_rel = (state_q == GRANT) && !done_hit &&
                       (hold_cnt_q == CNT_W'(MAX_HOLD - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hold_cnt_q <= '0;
        end else if (accept) begin
            hold_cnt_q <= '0;
        end else if (gnt_q != '0) begin
            hold_cnt_q <= hold_cnt_q + CNT_W'(1);
        end
    end
`else
    assign force_rel = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        gnt_d         = gnt_q;
        release_d     = 1'b0;
        release_idx_d = release_idx_q;
        err_d         = 1'b0;
        timeout_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    owner_d = i_idx;
                    gnt_d   = dec_onehot;
                    state_d = GRANT;
                end else if (reject) begin
                    err_d = 1'b1;
                end
            end
            GRANT: begin
                if (done_hit || force_rel) begin
                    gnt_d         = '0;
                    release_d     = 1'b1;
                    release_idx_d = owner_q;
                    timeout_d     = force_rel;
                    state_d       = IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= IDLE;
            owner_q       <= '0;
            gnt_q         <= '0;
            release_q     <= 1'b0;
            release_idx_q <= '0;
            err_q         <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            gnt_q         <= gnt_d;
            release_q     <= release_d;
            release_idx_q <= release_idx_d;
            err_q         <= err_d;
            timeout_q     <= timeout_d;
        end
    end

    assign o_ready       = (state_q == IDLE);
    assign o_gnt         = gnt_q;
    assign o_release     = release_q;
    assign o_release_idx = release_idx_q;
    assign o_err         = err_q;
    assign o_timeout     = timeout_q;
    assign o_state       = state_q;

endmodule

// File: tb/tb_grant_issuer.sv
// Self-checking bench for grant_issuer (WIDTH=4 main instance, WIDTH=5 for range rejects).
module tb_grant_issuer;
    import arb_pkg::*;

    logic         clk;
    logic         i_rst;
    logic [1:0]   i_idx;
    logic         i_valid;
    logic [3:0]   i_done;
    logic         o_ready, o_release, o_err, o_timeout;
    logic [3:0]   o_gnt;
    logic [1:0]   o_release_idx;
    grant_state_t o_state;

    logic [2:0]   i_idx5;
    logic         i_valid5;
    logic [4:0]   i_done5;
    logic         o_ready5, o_release5, o_err5, o_timeout5;
    logic [4:0]   o_gnt5;
    logic [2:0]   o_release_idx5;
    grant_state_t o_state5;

    int errors = 0;
    int checks = 0;

    logic [3:0] exp_q[$];
    logic [1:0] exp_rel_q[$];

    grant_issuer #(.WIDTH(4), .MAX_HOLD(16)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_idx(i_idx), .i_valid(i_valid),
        .o_ready(o_ready), .o_gnt(o_gnt), .i_done(i_done),
        .o_release(o_release), .o_release_idx(o_release_idx),
        .o_err(o_err), .o_timeout(o_timeout), .o_state(o_state)
    );

    grant_issuer #(.WIDTH(5), .MAX_HOLD(16)) dut5 (
        .i_clk(clk), .i_rst(i_rst), .i_idx(i_idx5), .i_valid(i_valid5),
        .o_ready(o_ready5), .o_gnt(o_gnt5), .i_done(i_done5),
        .o_release(o_release5), .o_release_idx(o_release_idx5),
        .o_err(o_err5), .o_timeout(o_timeout5), .o_state(o_state5)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // driver: present idx, expect a one-hot grant the following cycle
    task automatic do_grant(input logic [1:0] idx);
        checks++;
        if (o_ready !== 1'b1) begin
            errors++; $display("FAIL grant_ready: o_ready=%b expected 1", o_ready);
        end
        i_valid = 1'b1;
        i_idx   = idx;
        exp_q.push_back(4'b0001 << idx);
        tick();
        i_valid = 1'b0;
        begin
            logic [3:0] e;
            e = exp_q.pop_front();
            checks++;
            if (o_gnt !== e || o_ready !== 1'b0) begin
                errors++; $display("FAIL grant: o_gnt=%b o_ready=%b expected %b/0", o_gnt, o_ready, e);
            end
        end
    endtask

    // driver: assert the owner's done, expect release pulse next cycle
    task automatic do_release(input logic [1:0] idx);
        logic [1:0] e;
        i_done = 4'b0001 << idx;
        exp_rel_q.push_back(idx);
        tick();
        i_done = 4'b0000;
        e = exp_rel_q.pop_front();
        checks++;
        if (o_gnt !== 4'b0000 || o_release !== 1'b1 || o_release_idx !== e ||
            o_ready !== 1'b1 || o_timeout !== 1'b0) begin
            errors++;
            $display("FAIL release: gnt=%b rel=%b idx=%0d rdy=%b to=%b expected 0000/1/%0d/1/0",
                     o_gnt, o_release, o_release_idx, o_ready, o_timeout, e);
        end
        tick();
        checks++;
        if (o_release !== 1'b0 || o_release_idx !== e) begin
            errors++; $display("FAIL release_hold: rel=%b idx=%0d expected 0/%0d", o_release, o_release_idx, e);
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_valid = 1'b1; i_idx = 2'd1; i_done = '0;
        i_valid5 = 1'b0; i_idx5 = '0; i_done5 = '0;
        tick();
        tick();
        checks++;
        if (o_gnt !== 4'b0000 || o_release !== 1'b0 || o_err !== 1'b0 || o_timeout !== 1'b0) begin
            errors++; $display("FAIL reset_outputs: gnt=%b rel=%b err=%b to=%b expected all 0",
                               o_gnt, o_release, o_err, o_timeout);
        end
        i_rst = 1'b0; i_valid = 1'b0;
        checks++;
        if (o_ready !== 1'b1 || o_state !== IDLE || o_release_idx !== 2'd0 || o_gnt5 !== 5'b0) begin
            errors++; $display("FAIL reset_idle: rdy=%b state=%0d ridx=%0d gnt5=%b expected 1/0/0/00000",
                               o_ready, o_state, o_release_idx, o_gnt5);
        end
    endtask

    task automatic test_basic_grant();
        do_grant(2'd2);
        for (int c = 2; c <= 5; c++) begin
            tick();
            checks++;
            if (o_gnt !== 4'b0100 || o_release !== 1'b0 || o_state !== GRANT) begin
                errors++; $display("FAIL basic_hold c%0d: gnt=%b rel=%b expected 0100/0", c, o_gnt, o_release);
            end
        end
        do_release(2'd2);
    endtask

    task automatic test_foreign_done();
        do_grant(2'd2);
        i_done = 4'b0010; i_valid = 1'b1; i_idx = 2'd1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (o_gnt !== 4'b0100 || o_ready !== 1'b0 || o_release !== 1'b0) begin
                errors++; $display("FAIL foreign_hold: gnt=%b rdy=%b rel=%b expected 0100/0/0", o_gnt, o_ready, o_release);
            end
        end
        i_done = 4'b0110;
        tick();
        i_done = 4'b0000;
        checks++;
        if (o_gnt !== 4'b0000 || o_release !== 1'b1 || o_release_idx !== 2'd2 || o_ready !== 1'b1) begin
            errors++; $display("FAIL foreign_release: gnt=%b rel=%b idx=%0d rdy=%b expected 0000/1/2/1",
                               o_gnt, o_release, o_release_idx, o_ready);
        end
        exp_q.push_back(4'b0010);
        tick();
        i_valid = 1'b0;
        begin
            logic [3:0] e;
            e = exp_q.pop_front();
            checks++;
            if (o_gnt !== e) begin
                errors++; $display("FAIL pending_accept: gnt=%b expected %b", o_gnt, e);
            end
        end
        do_release(2'd1);
    endtask

    task automatic test_back_to_back();
        logic [1:0] cur, nxt;
        cur = 2'($urandom_range(0, 3));
        i_valid = 1'b1; i_idx = cur;
        exp_q.push_back(4'b0001 << cur);
        tick();
        for (int k = 0; k < 6; k++) begin
            begin
                logic [3:0] e;
                e = exp_q.pop_front();
                checks++;
                if (o_gnt !== e) begin
                    errors++; $display("FAIL b2b_grant k%0d: gnt=%b expected %b", k, o_gnt, e);
                end
            end
            nxt = 2'($urandom_range(0, 3));
            i_done = 4'b0001 << cur;
            i_idx  = nxt;
            exp_rel_q.push_back(cur);
            tick();
            i_done = 4'b0000;
            begin
                logic [1:0] r;
                r = exp_rel_q.pop_front();
                checks++;
                if (o_gnt !== 4'b0000 || o_release !== 1'b1 || o_release_idx !== r || o_ready !== 1'b1) begin
                    errors++; $display("FAIL b2b_release k%0d: gnt=%b rel=%b idx=%0d rdy=%b expected 0000/1/%0d/1",
                                       k, o_gnt, o_release, o_release_idx, o_ready, r);
                end
            end
            exp_q.push_back(4'b0001 << nxt);
            tick();
            cur = nxt;
        end
        i_valid = 1'b0;
        begin
            logic [3:0] e;
            e = exp_q.pop_front();
            checks++;
            if (o_gnt !== e) begin
                errors++; $display("FAIL b2b_last: gnt=%b expected %b", o_gnt, e);
            end
        end
        do_release(cur);
    endtask

    task automatic test_out_of_range();
        i_valid5 = 1'b1; i_idx5 = 3'd6;
        tick();
        i_valid5 = 1'b0;
        checks++;
        if (o_err5 !== 1'b1 || o_gnt5 !== 5'b00000 || o_ready5 !== 1'b1 || o_state5 !== IDLE) begin
            errors++; $display("FAIL oor_reject: err=%b gnt=%b rdy=%b expected 1/00000/1", o_err5, o_gnt5, o_ready5);
        end
        tick();
        checks++;
        if (o_err5 !== 1'b0 || o_gnt5 !== 5'b00000) begin
            errors++; $display("FAIL oor_pulse: err=%b gnt=%b expected 0/00000", o_err5, o_gnt5);
        end
        i_valid5 = 1'b1; i_idx5 = 3'd4;
        tick();
        i_valid5 = 1'b0;
        checks++;
        if (o_gnt5 !== 5'b10000 || o_err5 !== 1'b0 || o_ready5 !== 1'b0) begin
            errors++; $display("FAIL oor_top_idx: gnt=%b err=%b rdy=%b expected 10000/0/0", o_gnt5, o_err5, o_ready5);
        end
        i_done5 = 5'b10000;
        tick();
        i_done5 = 5'b00000;
        checks++;
        if (o_gnt5 !== 5'b00000 || o_release5 !== 1'b1 || o_release_idx5 !== 3'd4) begin
            errors++; $display("FAIL oor_release: gnt=%b rel=%b idx=%0d expected 00000/1/4", o_gnt5, o_release5, o_release_idx5);
        end
    endtask

    task automatic test_timeout();
`ifdef GRANT_TIMEOUT_EN
        do_grant(2'd3);
        for (int c = 2; c <= 16; c++) begin
            tick();
            checks++;
            if (o_gnt !== 4'b1000 || o_release !== 1'b0) begin
                errors++; $display("FAIL to_hold c%0d: gnt=%b rel=%b expected 1000/0", c, o_gnt, o_release);
            end
        end
        tick();
        checks++;
        if (o_gnt !== 4'b0000 || o_release !== 1'b1 || o_timeout !== 1'b1 || o_release_idx !== 2'd3) begin
            errors++; $display("FAIL to_force: gnt=%b rel=%b to=%b idx=%0d expected 0000/1/1/3",
                               o_gnt, o_release, o_timeout, o_release_idx);
        end
        tick();
        checks++;
        if (o_timeout !== 1'b0 || o_release !== 1'b0) begin
            errors++; $display("FAIL to_pulse: to=%b rel=%b expected 0/0", o_timeout, o_release);
        end
        do_grant(2'd3);
        for (int c = 2; c <= 16; c++) tick();
        i_done = 4'b1000;
        tick();
        i_done = 4'b0000;
        checks++;
        if (o_gnt !== 4'b0000 || o_release !== 1'b1 || o_timeout !== 1'b0 || o_release_idx !== 2'd3) begin
            errors++; $display("FAIL to_done_wins: gnt=%b rel=%b to=%b idx=%0d expected 0000/1/0/3",
                               o_gnt, o_release, o_timeout, o_release_idx);
        end
`else
        do_grant(2'd3);
        for (int c = 2; c <= 40; c++) begin
            tick();
            checks++;
            if (o_gnt !== 4'b1000 || o_release !== 1'b0 || o_timeout !== 1'b0) begin
                errors++; $display("FAIL no_timeout c%0d: gnt=%b rel=%b to=%b expected 1000/0/0",
                                   c, o_gnt, o_release, o_timeout);
            end
        end
        do_release(2'd3);
`endif
    endtask

    task automatic test_reset_mid_grant();
        do_grant(2'd0);
        tick();
        tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        checks++;
        if (o_gnt !== 4'b0000 || o_release !== 1'b0 || o_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid: gnt=%b rel=%b rdy=%b expected 0000/0/1", o_gnt, o_release, o_ready);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (o_release !== 1'b0 || o_gnt !== 4'b0000 || o_ready !== 1'b1) begin
                errors++; $display("FAIL rst_mid_after: gnt=%b rel=%b rdy=%b expected 0000/0/1", o_gnt, o_release, o_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_grant();
        test_foreign_done();
        test_back_to_back();
        test_out_of_range();
        test_timeout();
        test_reset_mid_grant();
        checks++;
        if (exp_q.size() != 0 || exp_rel_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: %0d grants, %0d releases left, expected 0/0",
                               exp_q.size(), exp_rel_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
